// File: rtl/fusion_pkg.sv
// Shared sizing constants and types for the fusion-core sensor ingest path.
package fusion_pkg;

    localparam int SENSOR_WORD_W = 16;
    localparam int SENSOR_WORDS  = 16;
    localparam int NUM_SENSORS   = 3;

    typedef logic [255:0] sensor_vec_t;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } aligner_state_t;

endpackage

// File: rtl/sensor_word_packer.sv
// One sensor lane: packs accepted words into a frame-wide buffer.
// Also reports lane-full and a one-cycle framing error on an early s_last.
module sensor_word_packer
    import fusion_pkg::*;
#(
    parameter int WORD_W          = SENSOR_WORD_W,
    parameter int WORDS_PER_FRAME = SENSOR_WORDS
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic                              enable,
    input  logic [WORD_W-1:0]                 word,
    input  logic                              valid,
    input  logic                              last,
    output logic                              ready,
    output logic                              full,
    output logic                              full_nxt,
    output logic [WORD_W*WORDS_PER_FRAME-1:0] vec,
    output logic                              framing_err
);

    localparam int CNT_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_FRAME - 1);

    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             at_last;
    logic             premature;

    assign ready     = enable & ~full;
    assign accept    = valid & ready;
    assign at_last   = (cnt == LAST_IDX);
    assign premature = accept & last & ~at_last;
    // Full as seen by the parent's next-state logic, including this cycle's word.
    assign full_nxt  = full | (accept & at_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            full        <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            framing_err <= premature;
            if (clear) begin
                cnt  <= '0;
                full <= 1'b0;
            end else if (accept) begin
                if (premature) begin
                    cnt <= '0;
                end else if (at_last) begin
                    cnt  <= '0;
                    full <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Stale words from a discarded frame are simply overwritten by the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec <= '0;
        end else if (accept && !premature) begin
            vec[WORD_W*int'(cnt) +: WORD_W] <= word;
        end
    end

endmodule

// File: rtl/sensor_frame_aligner.sv
// Aligns three packed sensor lanes into one frame with a skew timeout;
// late lanes are zero-filled and flagged in missing_mask.
module sensor_frame_aligner
    import fusion_pkg::*;
#(
    parameter int WORD_W          = SENSOR_WORD_W,
    parameter int WORDS_PER_FRAME = SENSOR_WORDS,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_SENSORS*WORD_W-1:0]     s_data,
    input  logic [NUM_SENSORS-1:0]            s_valid,
    input  logic [NUM_SENSORS-1:0]            s_last,
    output logic [NUM_SENSORS-1:0]            s_ready,
    output logic [WORD_W*WORDS_PER_FRAME-1:0] sensor1_raw,
    output logic [WORD_W*WORDS_PER_FRAME-1:0] sensor2_raw,
    output logic [WORD_W*WORDS_PER_FRAME-1:0] sensor3_raw,
    output logic                              frame_valid,
    output logic [NUM_SENSORS-1:0]            missing_mask,
    output logic [NUM_SENSORS-1:0]            framing_err,
    output logic [15:0]                       frame_count
);

    localparam int VEC_W = WORD_W * WORDS_PER_FRAME;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

    aligner_state_t         state;
    aligner_state_t         state_nxt;
    logic [TMR_W-1:0]       timer;
    logic [NUM_SENSORS-1:0] lane_full;
    logic [NUM_SENSORS-1:0] lane_full_nxt;
    logic [VEC_W-1:0]       lane_vec [NUM_SENSORS];
    logic                   all_done;
    logic                   first_done;
    logic                   timeout;

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_lane
        sensor_word_packer #(
            .WORD_W          (WORD_W),
            .WORDS_PER_FRAME (WORDS_PER_FRAME)
        ) u_packer (
            .clk         (clk),
            .rst_n       (rst_n),
            .clear       (state == EMIT),
            .enable      (state == COLLECT),
            .word        (s_data[g*WORD_W +: WORD_W]),
            .valid       (s_valid[g]),
            .last        (s_last[g]),
            .ready       (s_ready[g]),
            .full        (lane_full[g]),
            .full_nxt    (lane_full_nxt[g]),
            .vec         (lane_vec[g]),
            .framing_err (framing_err[g])
        );
    end

    assign all_done   = &lane_full_nxt;
    assign first_done = ~|lane_full & |lane_full_nxt;
    // Completion on the timeout edge takes precedence: timeout needs !all_done.
    assign timeout    = |lane_full & ~all_done & (timer == TMR_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (all_done || timeout) state_nxt = EMIT;
            EMIT:    state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Timer stays idle until the first lane of a frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state == EMIT || first_done) begin
            timer <= '0;
        end else if (|lane_full && !all_done) begin
            timer <= timer + 1'b1;
        end
    end

    // Output stage: vectors and mask only change on the edge ending EMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sensor1_raw  <= '0;
            sensor2_raw  <= '0;
            sensor3_raw  <= '0;
            missing_mask <= '0;
            frame_valid  <= 1'b0;
            frame_count  <= '0;
        end else begin
            frame_valid <= (state == EMIT);
            if (state == EMIT) begin
                sensor1_raw  <= lane_full[0] ? lane_vec[0] : '0;
                sensor2_raw  <= lane_full[1] ? lane_vec[1] : '0;
                sensor3_raw  <= lane_full[2] ? lane_vec[2] : '0;
                missing_mask <= ~lane_full;
                frame_count  <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sensor_frame_aligner.sv
// Directed bench for sensor_frame_aligner with hand-computed expectations.
module tb_sensor_frame_aligner;

    logic         clk;
    logic         rst_n;
    logic [47:0]  s_data;
    logic [2:0]   s_valid;
    logic [2:0]   s_last;
    logic [2:0]   s_ready;
    logic [255:0] sensor1_raw;
    logic [255:0] sensor2_raw;
    logic [255:0] sensor3_raw;
    logic         frame_valid;
    logic [2:0]   missing_mask;
    logic [2:0]   framing_err;
    logic [15:0]  frame_count;

    int checks   = 0;
    int failures = 0;

    sensor_frame_aligner dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .sensor1_raw  (sensor1_raw),
        .sensor2_raw  (sensor2_raw),
        .sensor3_raw  (sensor3_raw),
        .frame_valid  (frame_valid),
        .missing_mask (missing_mask),
        .framing_err  (framing_err),
        .frame_count  (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for exactly one edge, then drop valid/last.
    task automatic beat(input logic [2:0] v, input logic [2:0] l,
                        input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        s_valid = v;
        s_last  = l;
        s_data  = {w2, w1, w0};
        @(posedge clk);
        #1;
        s_valid = 3'b000;
        s_last  = 3'b000;
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        s_data  = '0;
        s_valid = 3'b000;
        s_last  = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_frame_valid", frame_valid, 0);
        check("rst_missing", missing_mask, 0);
        check("rst_framing_err", framing_err, 0);
        check("rst_count", frame_count, 0);
        check("rst_s1", sensor1_raw, 0);
        check("rst_s3", sensor3_raw, 0);
        rst_n = 1'b1;
        idle();

        // Aligned lockstep frame
        for (int k = 0; k < 16; k++)
            beat(3'b111, 3'b000, 16'h0000 + 16'(k), 16'h1000 + 16'(k), 16'h2000 + 16'(k));
        check("al_emit_ready", s_ready, 3'b000);
        check("al_emit_fv", frame_valid, 0);
        idle();
        check("al_fv", frame_valid, 1);
        check("al_s1_w0", sensor1_raw[15:0], 16'h0000);
        check("al_s1_w15", sensor1_raw[255:240], 16'h000F);
        check("al_s2_w5", sensor2_raw[95:80], 16'h1005);
        check("al_s3_w15", sensor3_raw[255:240], 16'h200F);
        check("al_missing", missing_mask, 0);
        check("al_count", frame_count, 1);
        check("al_ready_back", s_ready, 3'b111);
        idle();
        check("al_fv_drop", frame_valid, 0);
        check("al_hold", sensor1_raw[255:240], 16'h000F);

        // Skewed: lane 2 finishes well after lanes 0/1
        for (int k = 0; k < 16; k++)
            beat((k < 6) ? 3'b111 : 3'b011, 3'b000,
                 16'hA000 + 16'(k), 16'hB000 + 16'(k), 16'h2000 + 16'(k));
        check("sk_ready_wait", s_ready, 3'b100);
        repeat (4) idle();
        check("sk_ready_wait2", s_ready, 3'b100);
        for (int k = 6; k < 16; k++)
            beat(3'b100, 3'b000, 16'h0, 16'h0, 16'hC000 + 16'(k));
        idle();
        check("sk_fv", frame_valid, 1);
        check("sk_missing", missing_mask, 0);
        check("sk_s1_w15", sensor1_raw[255:240], 16'hA00F);
        check("sk_s2_w0", sensor2_raw[15:0], 16'hB000);
        check("sk_s3_w0", sensor3_raw[15:0], 16'h2000);
        check("sk_s3_w15", sensor3_raw[255:240], 16'hC00F);
        check("sk_count", frame_count, 2);

        // Timeout: lane 2 sends only 5 words
        for (int k = 0; k < 16; k++)
            beat((k < 5) ? 3'b111 : 3'b011, 3'b000,
                 16'h4000 + 16'(k), 16'h4100 + 16'(k), 16'h4200 + 16'(k));
        n = 0;
        while (!frame_valid && n < 200) begin
            idle();
            n++;
        end
        check("to_latency", n, 65);
        check("to_fv", frame_valid, 1);
        check("to_missing", missing_mask, 3'b100);
        check("to_s3_zero", sensor3_raw, 0);
        check("to_s2_w15", sensor2_raw[255:240], 16'h410F);
        check("to_count", frame_count, 3);
        for (int k = 0; k < 16; k++)
            beat(3'b111, 3'b000, 16'h3000 + 16'(k), 16'h3100 + 16'(k), 16'h3200 + 16'(k));
        idle();
        check("to_next_fv", frame_valid, 1);
        check("to_next_s3_w0", sensor3_raw[15:0], 16'h3200);
        check("to_next_s3_w15", sensor3_raw[255:240], 16'h320F);
        check("to_next_missing", missing_mask, 0);
        check("to_next_count", frame_count, 4);

        // Premature last on lane 1, word 7
        for (int k = 0; k < 8; k++)
            beat(3'b111, (k == 7) ? 3'b010 : 3'b000,
                 16'h6000 + 16'(k), 16'h5F00 + 16'(k), 16'h6200 + 16'(k));
        check("pl_err", framing_err, 3'b010);
        beat(3'b111, 3'b000, 16'h6008, 16'h5000, 16'h6208);
        check("pl_err_drop", framing_err, 3'b000);
        for (int k = 9; k < 16; k++)
            beat(3'b111, 3'b000, 16'h6000 + 16'(k), 16'h5000 + 16'(k - 8), 16'h6200 + 16'(k));
        for (int k = 8; k < 16; k++)
            beat(3'b010, 3'b000, 16'h0, 16'h5000 + 16'(k), 16'h0);
        idle();
        check("pl_fv", frame_valid, 1);
        check("pl_s2_w0", sensor2_raw[15:0], 16'h5000);
        check("pl_s2_w15", sensor2_raw[255:240], 16'h500F);
        check("pl_s1_w15", sensor1_raw[255:240], 16'h600F);
        check("pl_missing", missing_mask, 0);
        check("pl_count", frame_count, 5);

        // Coincidence: lane 2 completes on the timeout edge, then backpressure in EMIT
        for (int k = 0; k < 16; k++)
            beat((k < 15) ? 3'b111 : 3'b011, 3'b000,
                 16'h8000 + 16'(k), 16'h8100 + 16'(k), 16'h8200 + 16'(k));
        repeat (63) idle();
        beat(3'b100, 3'b000, 16'h0, 16'h0, 16'h820F);
        s_valid = 3'b001;
        s_data  = {16'h0, 16'h0, 16'h7000};
        check("co_emit_ready", s_ready, 3'b000);
        idle();
        check("co_fv", frame_valid, 1);
        check("co_missing", missing_mask, 0);
        check("co_s3_w15", sensor3_raw[255:240], 16'h820F);
        check("co_count", frame_count, 6);
        idle();
        s_valid = 3'b000;
        for (int k = 0; k < 16; k++)
            beat((k < 15) ? 3'b111 : 3'b110, 3'b000,
                 16'h7001 + 16'(k), 16'h7100 + 16'(k), 16'h7200 + 16'(k));
        idle();
        check("bp_fv", frame_valid, 1);
        check("bp_s1_w0", sensor1_raw[15:0], 16'h7000);
        check("bp_s1_w1", sensor1_raw[31:16], 16'h7001);
        check("bp_s1_w15", sensor1_raw[255:240], 16'h700F);
        check("bp_count", frame_count, 7);

        // Asynchronous reset mid-frame
        for (int k = 0; k < 8; k++)
            beat(3'b111, 3'b000, 16'h9000 + 16'(k), 16'h9100 + 16'(k), 16'h9200 + 16'(k));
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_fv", frame_valid, 0);
        check("mr_count", frame_count, 0);
        check("mr_s1", sensor1_raw, 0);
        check("mr_s3", sensor3_raw, 0);
        check("mr_missing", missing_mask, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        for (int k = 0; k < 16; k++)
            beat(3'b111, 3'b000, 16'hD000 + 16'(k), 16'hD100 + 16'(k), 16'hD200 + 16'(k));
        idle();
        check("mr_after_fv", frame_valid, 1);
        check("mr_after_count", frame_count, 1);
        check("mr_after_s1_w0", sensor1_raw[15:0], 16'hD000);
        check("mr_after_s1_w15", sensor1_raw[255:240], 16'hD00F);
        check("mr_after_missing", missing_mask, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
